// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// Radix-2 shift-add multiply and restoring divide; one bit per cycle.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d;
  logic [XLEN-1:0]   mag_b_q, mag_b_d;
  logic              neg_p_q, neg_p_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            is_div;
  logic            sgn_a_op;
  logic            sgn_b_op;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            div_ovf;
  logic            fast;
  logic            accept;

  logic [XLEN:0]     add_sum;
  logic [XLEN+1:0]   shifted;
  logic [XLEN+1:0]   trial;
  logic              ge;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   quo_fin;
  logic [XLEN-1:0]   rem_fin;
  logic [XLEN-1:0]   sel;

  // Operand decode: signedness, magnitudes and the divide fast path.
  always_comb begin
    is_div   = funct3[2];
    sgn_a_op = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b_op = (funct3 == 3'b001) || (funct3 == 3'b100) ||
               (funct3 == 3'b110);
    sa       = sgn_a_op & a[XLEN-1];
    sb       = sgn_b_op & b[XLEN-1];
    abs_a    = sa ? -a : a;
    abs_b    = sb ? -b : b;
    div_zero = is_div && (b == '0);
    div_ovf  = is_div && !funct3[0] &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
    fast     = div_zero | div_ovf;
    accept   = (state_q == IDLE) && start && !kill;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; kill always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = fast ? FIN : CALC;
      CALC: begin
        if (kill)              state_d = IDLE;
        else if (cnt_q == '0)  state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands, then one multiply or divide step per cycle.
  always_comb begin
    f3_d    = f3_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_p_d = neg_p_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    add_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} +
              (prod_q[0] ? {1'b0, mag_a_q} : '0);
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {2'b00, mag_b_q};
    ge      = !trial[XLEN+1];
    if (accept) begin
      f3_d    = funct3;
      mag_a_d = abs_a;
      mag_b_d = abs_b;
      cnt_d   = CW'(XLEN-1);
      if (fast) begin
        // Preload final values; no sign fix-up applies to them.
        neg_p_d = 1'b0;
        neg_q_d = 1'b0;
        neg_r_d = 1'b0;
        prod_d  = '0;
        quo_d   = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        rem_d   = div_zero ? {1'b0, a} : '0;
      end else begin
        neg_p_d = sa ^ sb;
        neg_q_d = sa ^ sb;
        neg_r_d = sa;
        prod_d  = {{XLEN{1'b0}}, abs_b};
        quo_d   = abs_a;
        rem_d   = '0;
      end
    end else if (state_q == CALC) begin
      cnt_d = cnt_q - CW'(1);
      if (f3_q[2]) begin
        rem_d = ge ? trial[XLEN:0] : shifted[XLEN:0];
        quo_d = {quo_q[XLEN-2:0], ge};
      end else begin
        prod_d = {add_sum, prod_q[XLEN-1:1]};
      end
    end
  end

  // Output logic: sign fix-up and result select in FIN.
  always_comb begin
    prod_fin = neg_p_q ? -prod_q : prod_q;
    quo_fin  = neg_q_q ? -quo_q : quo_q;
    rem_fin  = neg_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    sel      = rem_fin;
    unique case (1'b1)
      (f3_q == 3'b000):            sel = prod_fin[XLEN-1:0];
      (!f3_q[2] && f3_q != 3'b0):  sel = prod_fin[2*XLEN-1:XLEN];
      (f3_q[2] && !f3_q[1]):       sel = quo_fin;
      default:                     sel = rem_fin;
    endcase
    done_d   = 1'b0;
    result_d = result_q;
    if (state_q == FIN && !kill) begin
      done_d   = 1'b1;
      result_d = sel;
    end
    busy   = (state_q != IDLE);
    done   = done_q;
    result = result_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      f3_q     <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_p_q  <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      f3_q     <= f3_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      neg_p_q  <= neg_p_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq.
// Expected results and done cycles are queued at start, checked at done.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] last_res = '0;
  logic done_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    logic [63:0] p;
    int qi;
    case (f)
      3'd0: begin p = 64'(ux * uy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = 64'(ux * uy); return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == '1) return 32'h8000_0000;
        qi = $signed(x) / $signed(y);
        return qi;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == '1) return 32'h0;
        qi = $signed(x) % $signed(y);
        return qi;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f,
                                input logic [31:0] x,
                                input logic [31:0] y);
    if (f[2] && (y == 0)) return 2;
    if (f[2] && !f[0] && x == 32'h8000_0000 && y == '1) return 2;
    return 34;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("done_cycle", cyc, e.at);
        end
      end
      if (done && done_prev) chk("done_twice", 32'd1, 32'd0);
    end
    done_prev = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      step();
      n++;
    end
    if (sb_q.size() > 0) begin
      chk("timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp,
                       input int lat);
    int nb = 0;
    int n = 0;
    funct3 = f;
    a = x;
    b = y;
    start = 1'b1;
    sb_q.push_back('{res: exp, at: cyc + lat});
    last_res = exp;
    step();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    while (sb_q.size() > 0 && n < 100) begin
      if (busy) nb++;
      step();
      n++;
    end
    if (sb_q.size() > 0) begin
      chk("timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
    chk("busy_cycles", nb, lat - 1);
  endtask

  initial begin : stim
    int t;
    logic [2:0] f;
    logic [31:0] x;
    logic [31:0] y;

    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    reset = 1'b0;
    step();

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 34);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 34);
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 34);
    do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    do_op(3'd6, 32'd7, 32'd0, 32'd7, 2);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);

    for (int i = 0; i < 10; i++) begin
      f = 3'($urandom_range(0, 7));
      x = $urandom;
      y = (i % 4 == 0) ? 32'h0 : $urandom;
      do_op(f, x, y, ref_op(f, x, y), lat_of(f, x, y));
    end

    // Kill mid-CALC with an ignored restart in between.
    t = cyc;
    funct3 = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < t + 5) step();
    funct3 = 3'd5; a = 32'd9; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < t + 10) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_busy", busy, 0);
    chk("kill_result", result, last_res);
    funct3 = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
    sb_q.push_back('{res: 32'd14, at: t + 45});
    last_res = 32'd14;
    step();
    start = 1'b0;
    wait_idle();

    // Kill while in FIN suppresses done.
    t = cyc;
    funct3 = 3'd0; a = 32'd11; b = 32'd13; start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < t + 33) step();
    chk("fin_busy", busy, 1);
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("fin_kill_busy", busy, 0);
    repeat (3) step();
    chk("fin_kill_result", result, last_res);

    // Back-to-back: second start in the done cycle.
    t = cyc;
    funct3 = 3'd0; a = 32'd6; b = 32'd7; start = 1'b1;
    sb_q.push_back('{res: 32'd42, at: t + 34});
    step();
    start = 1'b0;
    while (cyc < t + 34) step();
    funct3 = 3'd7; a = 32'd50; b = 32'd8; start = 1'b1;
    sb_q.push_back('{res: 32'd2, at: t + 68});
    last_res = 32'd2;
    step();
    start = 1'b0;
    wait_idle();

    // Kill overrides start in IDLE.
    funct3 = 3'd0; a = 32'd1; b = 32'd1; start = 1'b1; kill = 1'b1;
    step();
    start = 1'b0; kill = 1'b0;
    chk("kill_start_busy", busy, 0);
    repeat (40) step();

    // Reset mid-CALC.
    t = cyc;
    funct3 = 3'd1; a = 32'd123; b = 32'd456; start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < t + 10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_busy", busy, 0);
    chk("rst2_done", done, 0);
    chk("rst2_result", result, 0);
    repeat (40) step();

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
